seq_shift_add_multiplier: RTL

Parametrised iterative shift-and-add multiplier. Processes one multiplier bit per clock, replacing the single-pass loop multiplier. Adds a start/ready/done handshake, selectable signed (two's complement) or unsigned operation, and a synchronous abort. Sits as a shared arithmetic unit on the datapath, driven by a controller that issues one product request at a time.

---
 rtl/seq_shift_add_multiplier_if.sv | 25 ++
 rtl/seq_shift_add_multiplier.sv | 91 +++++++++
 2 files changed

// File: rtl/seq_shift_add_multiplier_if.sv
// rtl/seq_shift_add_multiplier_if.sv - request/response bundle for the sequential multiplier
interface seq_shift_add_multiplier_if #(
  parameter int M = 8,
  parameter int N = 8
);
  logic           start;
  logic           sgn;
  logic           abort;
  logic [M-1:0]   A;
  logic [N-1:0]   B;
  logic           ready;
  logic           busy;
  logic           done;
  logic [M+N-1:0] C;

  modport master (
    output start, sgn, abort, A, B,
    input  ready, busy, done, C
  );

  modport slave (
    input  start, sgn, abort, A, B,
    output ready, busy, done, C
  );
endinterface

// File: rtl/seq_shift_add_multiplier.sv
// rtl/seq_shift_add_multiplier.sv - iterative shift-and-add multiplier, one multiplier bit per clock
// Define SEQ_MUL_EARLY_EXIT_EN to finish as soon as the remaining multiplier bits are all zero.
module seq_shift_add_multiplier #(
  parameter int M = 8,
  parameter int N = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  seq_shift_add_multiplier_if.slave  bus
);
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t         state, state_nxt;
  logic [M+N-1:0] a_sh, acc, acc_nxt, c_q;
  logic [N-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           neg, done_q;
  logic [M-1:0]   a_mag;
  logic [N-1:0]   b_mag;
  logic           accept, last, finish;

  // Datapath works on magnitudes; the sign is reapplied once at completion.
  always_comb begin
    a_mag   = (bus.sgn && bus.A[M-1]) ? -bus.A : bus.A;
    b_mag   = (bus.sgn && bus.B[N-1]) ? -bus.B : bus.B;
    acc_nxt = b_sh[0] ? (acc + a_sh) : acc;
`ifdef SEQ_MUL_EARLY_EXIT_EN
    last    = (cnt == CW'(N - 1)) || (b_sh[N-1:1] == '0);
`else
    last    = (cnt == CW'(N - 1));
`endif
    accept  = bus.start && (state != RUN);
    finish  = (state == RUN) && !bus.abort && last;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.start) state_nxt = RUN;
      RUN:     if (bus.abort) state_nxt = IDLE;
               else if (last) state_nxt = DONE;
      DONE:    if (bus.start) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.ready = (state != RUN);
    bus.busy  = (state == RUN);
    bus.done  = done_q;
    bus.C     = c_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      acc    <= '0;
      cnt    <= '0;
      neg    <= 1'b0;
      c_q    <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        a_sh <= {{N{1'b0}}, a_mag};
        b_sh <= b_mag;
        neg  <= bus.sgn & (bus.A[M-1] ^ bus.B[N-1]);
        acc  <= '0;
        cnt  <= '0;
      end else if (state == RUN) begin
        // On abort these updates are harmless: the state returns to IDLE.
        acc  <= acc_nxt;
        a_sh <= a_sh << 1;
        b_sh <= b_sh >> 1;
        cnt  <= cnt + CW'(1);
        if (finish) begin
          c_q    <= neg ? -acc_nxt : acc_nxt;
          done_q <= 1'b1;
        end
      end
    end
  end
endmodule
